muldiv_unit: RTL and testbench

Iterative multiply/divide execution unit for the multicycle CPU, implementing the eight RV32M operations selected by funct3 at a parametrised operand width. It sits beside the ALU in the execute stage. The controller FSM pulses `start` with operands and funct3, stalls while `busy` is high, and writes `result` back when `done` pulses. Unlike the single-cycle ALU decode path, it holds operation state across many cycles using a shift/add multiplier and a restoring divider.

---
 rtl/muldiv_unit.sv | 200 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide unit (shift-add multiply, restoring
//            divide); divider present only when MULDIV_DIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  localparam int c_cnt_w = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] c_min = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               fast_q, fast_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               illegal_q, illegal_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               w_sign_a, w_sign_b, w_neg_a, w_neg_b;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_full;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]     w_shift;
  logic [WIDTH-1:0]   w_diff;
  logic               w_ovf;
`endif

  // MULHSU treats srcA as signed and srcB as unsigned
  always_comb begin : p_operands
    w_sign_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    w_sign_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    w_neg_a  = w_sign_a & srcA[WIDTH-1];
    w_neg_b  = w_sign_b & srcB[WIDTH-1];
    w_mag_a  = w_neg_a ? -srcA : srcA;
    w_mag_b  = w_neg_b ? -srcB : srcB;
  end

  always_comb begin : p_next
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    fast_d    = fast_q;
    neg_d     = neg_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    w_sum     = '0;
    w_full    = '0;
`ifdef MULDIV_DIV_EN
    w_shift   = '0;
    w_diff    = '0;
    w_ovf     = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = funct3;
          fast_d  = 1'b0;
          cnt_d   = c_cnt_w'(WIDTH);
          neg_d   = (funct3[2] && funct3[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);
          mcand_d = funct3[2] ? w_mag_b : w_mag_a;
          acc_d   = {{WIDTH{1'b0}}, (funct3[2] ? w_mag_a : w_mag_b)};
          state_d = S_RUN;
`ifdef MULDIV_DIV_EN
          w_ovf = !funct3[0] && (srcA == c_min) && (&srcB);
          if (funct3[2] && ((srcB == '0) || w_ovf)) begin
            fast_d  = 1'b1;
            state_d = S_FIX;
            if (srcB == '0)
              acc_d = {{WIDTH{1'b0}}, (funct3[1] ? srcA : {WIDTH{1'b1}})};
            else
              acc_d = {{WIDTH{1'b0}}, (funct3[1] ? {WIDTH{1'b0}} : c_min)};
          end
`else
          if (funct3[2]) begin
            fast_d  = 1'b1;
            state_d = S_FIX;
            acc_d   = '0;
          end
`endif
        end
      end

      S_RUN: begin
        cnt_d = cnt_q - c_cnt_w'(1);
        if (cnt_q == c_cnt_w'(1))
          state_d = S_FIX;
        // acc = {partial product, remaining multiplier bits}
        w_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_d = {w_sum, acc_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        // acc = {partial remainder, dividend bits shifting into quotient}
        if (op_q[2]) begin
          w_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
          w_diff  = w_shift[WIDTH-1:0] - mcand_q;
          if (w_shift >= {1'b0, mcand_q})
            acc_d = {w_diff, acc_q[WIDTH-2:0], 1'b1};
          else
            acc_d = {w_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
`endif
      end

      S_FIX: begin
        state_d = S_DONE;
        w_full  = neg_q ? -acc_q : acc_q;
`ifdef MULDIV_DIV_EN
        illegal_d = 1'b0;
`else
        illegal_d = op_q[2];
`endif
        if (fast_q)
          result_d = acc_q[WIDTH-1:0];
        else if (op_q == 3'b000)
          result_d = w_full[WIDTH-1:0];
        else
          result_d = w_full[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
        if (!fast_q && op_q[2]) begin
          if (op_q[1])
            result_d = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          else
            result_d = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end
`endif
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin : p_regs
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      fast_q    <= 1'b0;
      neg_q     <= 1'b0;
      mcand_q   <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      fast_q    <= fast_d;
      neg_q     <= neg_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      result_q  <= result_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign illegal = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit (WIDTH=32), table vectors
//            with a result scoreboard; adapts to the MULDIV_DIV_EN build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
  localparam bit c_div_en = 1'b1;
`else
  localparam bit c_div_en = 1'b0;
`endif

  logic        clk, reset, start, busy, done, illegal;
  logic [2:0]  funct3;
  logic [31:0] srcA, srcB, result;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .srcA   (srcA),
    .srcB   (srcB),
    .busy   (busy),
    .done   (done),
    .result (result),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] f; logic [31:0] a; logic [31:0] b; logic [31:0] r; bit fast; } vec_t;
  typedef struct { logic [31:0] r; logic ill; int lat; } exp_t;

  exp_t sb[$];
  vec_t tbl[20];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one request, pushes its expectation, and checks it when done pulses.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] r, input bit fast,
                        input bit poke);
    exp_t e;
    int   lat, bc;
    bit   seen, stray;
    e.r = r; e.ill = 1'b0; e.lat = fast ? 1 : 33;
    if (!c_div_en && f[2]) begin
      e.r = '0; e.ill = 1'b1; e.lat = 1;
    end
    @(negedge clk);
    start = 1'b1; funct3 = f; srcA = a; srcB = b;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; funct3 = 3'($urandom); srcA = $urandom; srcB = $urandom;
    lat = 0; bc = 0; seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (busy) bc++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      start = (poke && lat == 5);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s timeout: no done within 100 cycles, expected after %0d", tag, e.lat);
      sb.delete();
    end else begin
      e = sb.pop_front();
      chk({tag, " result"}, result, e.r);
      chk({tag, " illegal"}, {31'd0, illegal}, {31'd0, e.ill});
      chk({tag, " latency"}, 32'(lat), 32'(e.lat));
      chk({tag, " busy_cycles"}, 32'(bc), 32'(e.lat));
      if (poke) begin
        start = 1'b1; funct3 = 3'b000; srcA = 32'd1; srcB = 32'd1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
        chk({tag, " start_in_done_ignored"}, {31'd0, busy}, 32'd0);
        stray = 1'b0;
        repeat (40) begin
          @(negedge clk);
          if (done) stray = 1'b1;
        end
        chk({tag, " no_stray_done"}, {31'd0, stray}, 32'd0);
      end
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b0; start = 1'b0; funct3 = '0; srcA = '0; srcB = '0;
    #2 reset = 1'b1;
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset illegal", {31'd0, illegal}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    tbl[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    tbl[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
    tbl[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    tbl[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    tbl[4]  = '{3'b001, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0};
    tbl[5]  = '{3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0};
    tbl[6]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
    tbl[7]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
    tbl[8]  = '{3'b101, 32'd100,       32'd7,         32'h0000_000E, 1'b0};
    tbl[9]  = '{3'b111, 32'd100,       32'd7,         32'h0000_0002, 1'b0};
    tbl[10] = '{3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0};
    tbl[11] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    tbl[12] = '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1};
    tbl[13] = '{3'b110, 32'd5,         32'd0,         32'h0000_0005, 1'b1};
    tbl[14] = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1};
    tbl[15] = '{3'b111, 32'd7,         32'd0,         32'h0000_0007, 1'b1};
    tbl[16] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    tbl[17] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    tbl[18] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    tbl[19] = '{3'b000, 32'd6,         32'd7,         32'd42,        1'b0};

    for (int i = 0; i < 20; i++)
      run_op($sformatf("vec%0d", i), tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].fast, i == 0);

    // Abort a multiply part-way with an asynchronous reset.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; srcA = 32'd5; srcB = 32'd9;
    sb.push_back('{32'd45, 1'b0, 33});
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort result", result, 32'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    run_op("post_reset_mul", 3'b000, 32'd3, 32'd4, 32'd12, 1'b0, 1'b0);
    chk("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
